// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states and port identifiers.
package mem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and shared memory port seen by mem_arbiter.
// master = the arbiter itself; slave = the clients and the memory around it.
interface mem_arbiter_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_done;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic [3:0]  dmem_writeb;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_done;
    logic [31:0] dmem_rdata;
    logic        bus_err;
    logic        mem_req;
    logic [3:0]  mem_writeb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        input  imem_req, imem_addr, dmem_req, dmem_writeb, dmem_addr, dmem_wdata,
        input  mem_ready, mem_rdata,
        output imem_gnt, imem_done, imem_rdata, dmem_gnt, dmem_done, dmem_rdata,
        output bus_err, mem_req, mem_writeb, mem_addr, mem_wdata
    );

    modport slave (
        output imem_req, imem_addr, dmem_req, dmem_writeb, dmem_addr, dmem_wdata,
        output mem_ready, mem_rdata,
        input  imem_gnt, imem_done, imem_rdata, dmem_gnt, dmem_done, dmem_rdata,
        input  bus_err, mem_req, mem_writeb, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory port, one access at a time,
// with round-robin or dmem-first priority and a wait-cycle timeout.
module mem_arbiter #(
    parameter int FAIR     = 1,
    parameter int MAX_WAIT = 16
) (
    input logic           clk,
    input logic           reset,
    mem_arbiter_if.master bus
);
    import mem_arb_pkg::*;

    localparam logic       LP_FAIR = (FAIR != 0);
    localparam logic [7:0] LP_LAST = 8'(MAX_WAIT - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_last;
    logic [7:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_writeb;
    logic        r_imem_gnt;
    logic        r_dmem_gnt;
    logic        r_imem_done;
    logic        r_dmem_done;
    logic [31:0] r_imem_rdata;
    logic [31:0] r_dmem_rdata;
    logic        r_bus_err;

    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_ready;
    logic        w_timeout;
    logic        w_busy;

    assign w_busy = (r_state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        w_ready   = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.imem_req && bus.dmem_req) begin
                    // On a tie, round-robin favours whichever port did not win last time.
                    if (LP_FAIR && (r_last == PORT_D)) w_grant_i = 1'b1;
                    else                               w_grant_d = 1'b1;
                end else if (bus.imem_req) begin
                    w_grant_i = 1'b1;
                end else if (bus.dmem_req) begin
                    w_grant_d = 1'b1;
                end
                if (w_grant_i) w_next = BUSY_I;
                if (w_grant_d) w_next = BUSY_D;
            end
            BUSY_I, BUSY_D: begin
                // A ready arriving in the final allowed cycle beats the timeout.
                if (bus.mem_ready) begin
                    w_ready = 1'b1;
                    w_next  = IDLE;
                end else if (r_cnt == LP_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last       <= PORT_D;
            r_cnt        <= 8'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_writeb     <= 4'd0;
            r_imem_gnt   <= 1'b0;
            r_dmem_gnt   <= 1'b0;
            r_imem_done  <= 1'b0;
            r_dmem_done  <= 1'b0;
            r_imem_rdata <= 32'd0;
            r_dmem_rdata <= 32'd0;
            r_bus_err    <= 1'b0;
        end else begin
            r_imem_gnt  <= w_grant_i;
            r_dmem_gnt  <= w_grant_d;
            r_imem_done <= (r_state == BUSY_I) && (w_ready || w_timeout);
            r_dmem_done <= (r_state == BUSY_D) && (w_ready || w_timeout);
            r_bus_err   <= w_timeout;

            if (w_grant_i) begin
                r_last   <= PORT_I;
                r_cnt    <= 8'd0;
                r_addr   <= bus.imem_addr;
                r_wdata  <= 32'd0;
                r_writeb <= 4'd0;
            end else if (w_grant_d) begin
                r_last   <= PORT_D;
                r_cnt    <= 8'd0;
                r_addr   <= bus.dmem_addr;
                r_wdata  <= bus.dmem_wdata;
                r_writeb <= bus.dmem_writeb;
            end else if (w_busy && !w_ready) begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (r_state == BUSY_I) begin
                if (w_ready)        r_imem_rdata <= bus.mem_rdata;
                else if (w_timeout) r_imem_rdata <= 32'd0;
            end
            if (r_state == BUSY_D) begin
                if (w_ready)        r_dmem_rdata <= bus.mem_rdata;
                else if (w_timeout) r_dmem_rdata <= 32'd0;
            end
        end
    end

    assign bus.mem_req    = w_busy;
    assign bus.mem_writeb = w_busy ? r_writeb : 4'd0;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_wdata  = r_wdata;
    assign bus.imem_gnt   = r_imem_gnt;
    assign bus.dmem_gnt   = r_dmem_gnt;
    assign bus.imem_done  = r_imem_done;
    assign bus.dmem_done  = r_dmem_done;
    assign bus.imem_rdata = r_imem_rdata;
    assign bus.dmem_rdata = r_dmem_rdata;
    assign bus.bus_err    = r_bus_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance (MAX_WAIT=16) and a
// dmem-first instance (MAX_WAIT=4) share clock and reset.
module tb_mem_arbiter;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_fail;

    mem_arbiter_if bf ();
    mem_arbiter_if bx ();

    mem_arbiter #(.FAIR(1), .MAX_WAIT(16)) u_fair (.clk(clk), .reset(reset), .bus(bf.master));
    mem_arbiter #(.FAIR(0), .MAX_WAIT(4))  u_fix  (.clk(clk), .reset(reset), .bus(bx.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_vec++;
        if ({bf.imem_gnt, bf.imem_done, bf.dmem_gnt, bf.dmem_done, bf.bus_err, bf.mem_req} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, expected 000000",
                     {bf.imem_gnt, bf.imem_done, bf.dmem_gnt, bf.dmem_done, bf.bus_err, bf.mem_req});
        end
        n_vec++;
        if ({bf.imem_rdata, bf.dmem_rdata} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h, expected 0", {bf.imem_rdata, bf.dmem_rdata});
        end
        n_vec++;
        if ({bf.mem_writeb, bf.mem_addr, bf.mem_wdata} !== 68'd0) begin
            n_fail++;
            $display("FAIL reset_membus: got %h, expected 0", {bf.mem_writeb, bf.mem_addr, bf.mem_wdata});
        end
        n_vec++;
        if (bx.mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fix_memreq: got %b, expected 0", bx.mem_req);
        end
        reset = 1'b0;
        bf.mem_ready = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({bf.imem_done, bf.dmem_done, bf.bus_err, bf.mem_req} !== 4'b0) begin
            n_fail++;
            $display("FAIL idle_ready_ignored: got %b, expected 0000",
                     {bf.imem_done, bf.dmem_done, bf.bus_err, bf.mem_req});
        end
        bf.mem_ready = 1'b0;
    endtask

    task automatic test_single_fetch();
        bf.imem_req   = 1'b1;
        bf.imem_addr  = 32'h100;
        bf.mem_ready  = 1'b1;
        bf.mem_rdata  = 32'h0000_0013;
        tick();
        n_vec++;
        if ({bf.imem_gnt, bf.imem_done, bf.mem_req, bf.mem_writeb, bf.mem_addr} !== {3'b101, 4'h0, 32'h100}) begin
            n_fail++;
            $display("FAIL fetch_gnt: got %h, expected %h",
                     {bf.imem_gnt, bf.imem_done, bf.mem_req, bf.mem_writeb, bf.mem_addr}, {3'b101, 4'h0, 32'h100});
        end
        bf.imem_req = 1'b0;
        tick();
        n_vec++;
        if ({bf.imem_gnt, bf.imem_done, bf.bus_err, bf.mem_req, bf.imem_rdata} !== {4'b0100, 32'h13}) begin
            n_fail++;
            $display("FAIL fetch_done: got %h, expected %h",
                     {bf.imem_gnt, bf.imem_done, bf.bus_err, bf.mem_req, bf.imem_rdata}, {4'b0100, 32'h13});
        end
        bf.mem_rdata = 32'hFFFF_FFFF;
        tick();
        n_vec++;
        if ({bf.imem_done, bf.imem_rdata} !== {1'b0, 32'h13}) begin
            n_fail++;
            $display("FAIL fetch_hold: got %h, expected %h", {bf.imem_done, bf.imem_rdata}, {1'b0, 32'h13});
        end
        bf.mem_ready = 1'b0;
    endtask

    task automatic test_fair_tie();
        logic [1:0] exp_g;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bf.imem_req  = 1'b1;
        bf.dmem_req  = 1'b1;
        bf.imem_addr = 32'h400;
        bf.dmem_addr = 32'h800;
        bf.mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bf.mem_rdata = 32'hC0DE_0000 + 32'(k);
            exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
            tick();
            n_vec++;
            if ({bf.imem_gnt, bf.dmem_gnt} !== exp_g) begin
                n_fail++;
                $display("FAIL fair_gnt[%0d]: got %b, expected %b", k, {bf.imem_gnt, bf.dmem_gnt}, exp_g);
            end
            if (exp_g[1]) bf.imem_req = 1'b0;
            else          bf.dmem_req = 1'b0;
            tick();
            n_vec++;
            if ({bf.imem_done, bf.dmem_done, (exp_g[1] ? bf.imem_rdata : bf.dmem_rdata)}
                !== {exp_g, 32'hC0DE_0000 + 32'(k)}) begin
                n_fail++;
                $display("FAIL fair_done[%0d]: got %b/%h, expected %b/%h", k, {bf.imem_done, bf.dmem_done},
                         exp_g[1] ? bf.imem_rdata : bf.dmem_rdata, exp_g, 32'hC0DE_0000 + 32'(k));
            end
            if (k < 3) begin
                bf.imem_req = 1'b1;
                bf.dmem_req = 1'b1;
            end else begin
                bf.imem_req = 1'b0;
                bf.dmem_req = 1'b0;
            end
        end
        bf.mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_fixed_tie();
        bx.imem_req  = 1'b1;
        bx.dmem_req  = 1'b1;
        bx.dmem_addr = 32'h900;
        bx.mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bx.mem_rdata = 32'hA5A5_0000 + 32'(k);
            tick();
            n_vec++;
            if ({bx.imem_gnt, bx.dmem_gnt} !== 2'b01) begin
                n_fail++;
                $display("FAIL fixed_gnt[%0d]: got %b, expected 01", k, {bx.imem_gnt, bx.dmem_gnt});
            end
            bx.dmem_req = 1'b0;
            tick();
            n_vec++;
            if ({bx.imem_done, bx.dmem_done, bx.dmem_rdata} !== {2'b01, 32'hA5A5_0000 + 32'(k)}) begin
                n_fail++;
                $display("FAIL fixed_done[%0d]: got %h, expected %h", k,
                         {bx.imem_done, bx.dmem_done, bx.dmem_rdata}, {2'b01, 32'hA5A5_0000 + 32'(k)});
            end
            if (k < 3) bx.dmem_req = 1'b1;
            else       bx.imem_req = 1'b0;
        end
        bx.mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_store();
        bf.dmem_req    = 1'b1;
        bf.dmem_writeb = 4'h3;
        bf.dmem_addr   = 32'h2002;
        bf.dmem_wdata  = 32'hDEAD_BEEF;
        bf.mem_ready   = 1'b0;
        bf.mem_rdata   = 32'h0000_0055;
        tick();
        for (int c = 1; c <= 4; c++) begin
            n_vec++;
            if ({bf.dmem_gnt, bf.dmem_done, bf.mem_req, bf.mem_writeb, bf.mem_addr, bf.mem_wdata}
                !== {(c == 1), 2'b01, 4'h3, 32'h2002, 32'hDEAD_BEEF}) begin
                n_fail++;
                $display("FAIL store_busy[%0d]: got %h, expected %h", c,
                         {bf.dmem_gnt, bf.dmem_done, bf.mem_req, bf.mem_writeb, bf.mem_addr, bf.mem_wdata},
                         {(c == 1), 2'b01, 4'h3, 32'h2002, 32'hDEAD_BEEF});
            end
            if (c == 1) begin
                bf.dmem_req    = 1'b0;
                bf.dmem_writeb = 4'h0;
                bf.dmem_addr   = 32'hFFFF_FFFF;
                bf.dmem_wdata  = 32'h0;
            end
            if (c < 4) begin
                tick();
                if (c == 3) bf.mem_ready = 1'b1;
            end
        end
        tick();
        n_vec++;
        if ({bf.dmem_done, bf.bus_err, bf.mem_req, bf.mem_writeb, bf.dmem_rdata} !== {3'b100, 4'h0, 32'h55}) begin
            n_fail++;
            $display("FAIL store_done: got %h, expected %h",
                     {bf.dmem_done, bf.bus_err, bf.mem_req, bf.mem_writeb, bf.dmem_rdata}, {3'b100, 4'h0, 32'h55});
        end
        bf.mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        bx.dmem_req    = 1'b1;
        bx.dmem_writeb = 4'h0;
        bx.dmem_addr   = 32'h40;
        bx.mem_ready   = 1'b0;
        bx.mem_rdata   = 32'h7777_7777;
        tick();
        bx.dmem_req = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            n_vec++;
            if ({bx.dmem_gnt, bx.dmem_done, bx.bus_err, bx.mem_req} !== {(c == 1), 3'b001}) begin
                n_fail++;
                $display("FAIL timeout_busy[%0d]: got %b, expected %b", c,
                         {bx.dmem_gnt, bx.dmem_done, bx.bus_err, bx.mem_req}, {(c == 1), 3'b001});
            end
            tick();
        end
        n_vec++;
        if ({bx.dmem_done, bx.bus_err, bx.mem_req, bx.dmem_rdata} !== {3'b110, 32'h0}) begin
            n_fail++;
            $display("FAIL timeout_done: got %h, expected %h",
                     {bx.dmem_done, bx.bus_err, bx.mem_req, bx.dmem_rdata}, {3'b110, 32'h0});
        end
        tick();
        n_vec++;
        if ({bx.dmem_done, bx.bus_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_pulse: got %b, expected 00", {bx.dmem_done, bx.bus_err});
        end
    endtask

    task automatic test_timeout_ready();
        bx.dmem_req  = 1'b1;
        bx.dmem_addr = 32'h44;
        bx.mem_ready = 1'b0;
        bx.mem_rdata = 32'h1234_5678;
        tick();
        bx.dmem_req = 1'b0;
        tick();
        tick();
        tick();
        bx.mem_ready = 1'b1;
        n_vec++;
        if ({bx.dmem_done, bx.mem_req} !== 2'b01) begin
            n_fail++;
            $display("FAIL late_ready_busy4: got %b, expected 01", {bx.dmem_done, bx.mem_req});
        end
        tick();
        n_vec++;
        if ({bx.dmem_done, bx.bus_err, bx.mem_req, bx.dmem_rdata} !== {3'b100, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL late_ready_done: got %h, expected %h",
                     {bx.dmem_done, bx.bus_err, bx.mem_req, bx.dmem_rdata}, {3'b100, 32'h1234_5678});
        end
        bx.mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bf.imem_req  = 1'b1;
        bf.imem_addr = 32'h300;
        bf.mem_ready = 1'b0;
        tick();
        bf.imem_req = 1'b0;
        tick();
        n_vec++;
        if ({bf.imem_gnt, bf.mem_req} !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_busy2: got %b, expected 01", {bf.imem_gnt, bf.mem_req});
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if (bf.mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async_drop: got %b, expected 0", bf.mem_req);
        end
        tick();
        reset = 1'b0;
        bf.mem_ready = 1'b1;
        tick();
        n_vec++;
        if ({bf.imem_done, bf.dmem_done, bf.bus_err, bf.mem_req} !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_no_done: got %b, expected 0000",
                     {bf.imem_done, bf.dmem_done, bf.bus_err, bf.mem_req});
        end
        bf.imem_req = 1'b1;
        bf.dmem_req = 1'b1;
        tick();
        n_vec++;
        if ({bf.imem_gnt, bf.dmem_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_next_tie: got %b, expected 10", {bf.imem_gnt, bf.dmem_gnt});
        end
        bf.imem_req = 1'b0;
        bf.dmem_req = 1'b0;
        bf.mem_ready = 1'b0;
        tick();
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        reset  = 1'b1;
        bf.imem_req = 1'b0; bf.imem_addr = 32'd0; bf.dmem_req = 1'b0; bf.dmem_writeb = 4'd0;
        bf.dmem_addr = 32'd0; bf.dmem_wdata = 32'd0; bf.mem_ready = 1'b0; bf.mem_rdata = 32'd0;
        bx.imem_req = 1'b0; bx.imem_addr = 32'd0; bx.dmem_req = 1'b0; bx.dmem_writeb = 4'd0;
        bx.dmem_addr = 32'd0; bx.dmem_wdata = 32'd0; bx.mem_ready = 1'b0; bx.mem_rdata = 32'd0;

        test_reset();
        test_single_fetch();
        test_fair_tie();
        test_fixed_tie();
        test_store();
        test_timeout();
        test_timeout_ready();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
